// File: rtl/leg_dbg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : leg_dbg_pkg
// Description : Command/response byte codes and FSM state encoding for the
//               UART-driven debug bus master.
// Revision    : 1.0 - initial release
// ============================================================================
package leg_dbg_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;   // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;   // 'R'
    localparam logic [7:0] RSP_OK    = 8'h4B;   // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h3F;   // '?'

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_BUS_WR = 3'd3,
        S_BUS_RD = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    // Plain-vector views of the state encoding for the FSM register
    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_ADDR   = S_ADDR;
    localparam logic [2:0] ST_WDATA  = S_WDATA;
    localparam logic [2:0] ST_BUS_WR = S_BUS_WR;
    localparam logic [2:0] ST_BUS_RD = S_BUS_RD;
    localparam logic [2:0] ST_RESP   = S_RESP;

endpackage
`default_nettype wire

// File: rtl/uart_bus_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_bus_master_if
// Description : UART RX/TX byte streams and CPU-bus request signals of the
//               UART bus master, with master (block) and slave (env) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_bus_master_if;

    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [31:0] o_addr;
    logic [31:0] o_data;
    logic        o_wr_valid;
    logic        i_wr_ready;
    logic [31:0] i_data;
    logic        i_rd_valid;
    logic        o_rd_ready;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_wr_ready, i_data, i_rd_valid,
        output o_rx_ready, o_tx_data, o_tx_valid, o_addr, o_data, o_wr_valid, o_rd_ready
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_wr_ready, i_data, i_rd_valid,
        input  o_rx_ready, o_tx_data, o_tx_valid, o_addr, o_data, o_wr_valid, o_rd_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_bus_master
// Description : Decodes 'W'/'R' UART frames into single 32-bit bus writes and
//               reads and returns 'K', the read data, or '?' over UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_master
    import leg_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    uart_bus_master_if.master bus,
    output logic              o_busy,
    output logic              o_error
);

    localparam int unsigned        TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q,    state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       cmd_q,      cmd_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      data_q,     data_d;
    logic [31:0]      resp_q,     resp_d;
    logic [TMR_W-1:0] timer_q,    timer_d;
    logic             error_q,    error_d;

    logic w_rx_fire;
    logic w_tx_fire;

    // rx_ready is also gated by reset so nothing is taken while rst is held
    assign bus.o_rx_ready = i_rst & ((state_q == ST_IDLE) | (state_q == ST_ADDR) |
                                     (state_q == ST_WDATA));
    assign bus.o_wr_valid = (state_q == ST_BUS_WR);
    assign bus.o_rd_ready = (state_q == ST_BUS_RD);
    assign bus.o_tx_valid = (state_q == ST_RESP);
    assign bus.o_tx_data  = resp_q[31:24];
    assign bus.o_addr     = addr_q;
    assign bus.o_data     = data_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_error        = error_q;

    assign w_rx_fire = bus.i_rx_valid & bus.o_rx_ready;
    assign w_tx_fire = bus.o_tx_valid & bus.i_tx_ready;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resp_d     = resp_q;
        timer_d    = timer_q;
        error_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    cmd_d      = bus.i_rx_data;
                    byte_cnt_d = 2'd0;
                    timer_d    = '0;
                    if ((bus.i_rx_data == CMD_WRITE) || (bus.i_rx_data == CMD_READ)) begin
                        state_d = ST_ADDR;
                    end else begin
                        resp_d  = {RSP_ERR, 24'h0};
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (w_rx_fire) begin
                    addr_d     = {addr_q[23:0], bus.i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    timer_d    = '0;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (cmd_q == CMD_READ) ? ST_BUS_RD : ST_WDATA;
                    end
                end else if (timer_q == TMR_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_WDATA: begin
                if (w_rx_fire) begin
                    data_d     = {data_q[23:0], bus.i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    timer_d    = '0;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_BUS_WR;
                    end
                end else if (timer_q == TMR_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_BUS_WR: begin
                if (bus.i_wr_ready) begin
                    resp_d     = {RSP_OK, 24'h0};
                    byte_cnt_d = 2'd0;
                    state_d    = ST_RESP;
                end
            end

            ST_BUS_RD: begin
                if (bus.i_rd_valid) begin
                    resp_d     = bus.i_data;
                    byte_cnt_d = 2'd3;
                    state_d    = ST_RESP;
                end
            end

            ST_RESP: begin
                // byte_cnt holds the number of response bytes still to follow
                if (w_tx_fire) begin
                    if (byte_cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        resp_d     = {resp_q[23:0], 8'h00};
                        byte_cnt_d = byte_cnt_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            cmd_q      <= 8'h00;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            resp_q     <= 32'h0;
            timer_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            timer_q    <= timer_d;
            error_q    <= error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_master
// Description : Randomized self-checking bench for uart_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;

    localparam int unsigned TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic error;

    uart_bus_master_if bus ();

    uart_bus_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .bus     (bus),
        .o_busy  (busy),
        .o_error (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // environment knobs
    int          wr_delay = 0;
    int          rd_delay = 0;
    int          tx_stall = 0;
    logic [31:0] rd_data_val = 32'h0;
    int          wc = 0, rc = 0, tc = 0;

    // observation logs
    logic [7:0]  tx_q[$];
    logic [63:0] wr_q[$];
    int          wr_len_q[$];
    logic [31:0] rd_q[$];
    int          err_pulses = 0, err_cycles = 0;
    int          overlap = 0, tx_unstable = 0, wr_unstable = 0;
    int          wr_run = 0;
    logic        err_prev = 1'b0, tx_hold = 1'b0;
    logic [7:0]  tx_hold_val = 8'h0;
    logic [63:0] wr_prev = 64'h0;

    initial begin
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
    end

    // Bus slave and TX sink with programmable wait/stall lengths
    initial begin
        bus.i_wr_ready = 1'b0;
        bus.i_rd_valid = 1'b0;
        bus.i_tx_ready = 1'b0;
        bus.i_data     = 32'h0;
        forever begin
            @(posedge clk); #1;
            bus.i_data = rd_data_val;
            if (bus.o_wr_valid) begin
                bus.i_wr_ready = (wc == wr_delay);
                wc = (wc == wr_delay) ? 0 : wc + 1;
            end else begin
                bus.i_wr_ready = 1'b0; wc = 0;
            end
            if (bus.o_rd_ready) begin
                bus.i_rd_valid = (rc == rd_delay);
                rc = (rc == rd_delay) ? 0 : rc + 1;
            end else begin
                bus.i_rd_valid = 1'b0; rc = 0;
            end
            if (bus.o_tx_valid) begin
                bus.i_tx_ready = (tc == tx_stall);
                tc = (tc == tx_stall) ? 0 : tc + 1;
            end else begin
                bus.i_tx_ready = 1'b0; tc = 0;
            end
        end
    end

    // Monitor: logs completed handshakes and protocol violations
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_tx_valid && bus.i_tx_ready) tx_q.push_back(bus.o_tx_data);
            if (tx_hold && bus.o_tx_valid && (bus.o_tx_data !== tx_hold_val)) tx_unstable++;
            tx_hold     = bus.o_tx_valid && !bus.i_tx_ready;
            tx_hold_val = bus.o_tx_data;
            if (bus.o_wr_valid) begin
                wr_run++;
                if (wr_run > 1 && {bus.o_addr, bus.o_data} !== wr_prev) wr_unstable++;
                wr_prev = {bus.o_addr, bus.o_data};
                if (bus.i_wr_ready) begin
                    wr_q.push_back({bus.o_addr, bus.o_data});
                    wr_len_q.push_back(wr_run);
                    wr_run = 0;
                end
            end else begin
                wr_run = 0;
            end
            if (bus.o_rd_ready && bus.i_rd_valid) rd_q.push_back(bus.o_addr);
            if (error) err_cycles++;
            if (error && !err_prev) err_pulses++;
            err_prev = error;
            if (bus.o_wr_valid && bus.o_rd_ready) overlap++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        tx_q.delete(); wr_q.delete(); wr_len_q.delete(); rd_q.delete();
        err_pulses = 0; err_cycles = 0;
    endtask

    function automatic logic [31:0] tx_packed();
        logic [31:0] v = 32'h0;
        for (int i = 0; i < tx_q.size() && i < 4; i++) v = {v[23:0], tx_q[i]};
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        bit acc;
        repeat (gap) begin @(posedge clk); #1; end
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); acc = bus.o_rx_ready;
            @(posedge clk); #1;
            if (acc) begin ok = 1'b1; break; end
        end
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                              input logic [31:0] d, input int max_gap, output bit ok);
        bit o;
        send_byte(cmd, $urandom_range(0, max_gap), ok);
        if (cmd == 8'h57 || cmd == 8'h52) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(a[31-8*i -: 8], $urandom_range(0, max_gap), o); ok &= o;
            end
        end
        if (cmd == 8'h57) begin
            for (int i = 0; i < 4; i++) begin
                send_byte(d[31-8*i -: 8], $urandom_range(0, max_gap), o); ok &= o;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_rx_valid = 1'b1; bus.i_rx_data = 8'h57;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_rx_ready, bus.o_tx_valid, bus.o_wr_valid, bus.o_rd_ready, busy, error} !== 6'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b required 000000",
                {bus.o_rx_ready, bus.o_tx_valid, bus.o_wr_valid, bus.o_rd_ready, busy, error}); end
        checks++;
        if (bus.o_addr !== 32'h0 || bus.o_data !== 32'h0 || bus.o_tx_data !== 8'h0)
            begin errors++; $display("FAIL reset_data: addr %h data %h tx %h required zeros",
                bus.o_addr, bus.o_data, bus.o_tx_data); end
        @(posedge clk); #1;
        bus.i_rx_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_rx_ready !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL first_ready: rx_ready %b busy %b required 1 0",
                bus.o_rx_ready, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        bit ok, ok2;
        clear_logs(); wr_delay = 3; tx_stall = 0;
        send_frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 0, ok);
        @(negedge clk);
        checks++;
        if (bus.o_wr_valid !== 1'b1)
            begin errors++; $display("FAIL wr_latency: wr_valid %b required 1", bus.o_wr_valid); end
        wait_idle(ok2);
        checks++;
        if (!(ok && ok2) || wr_q.size() != 1 || wr_q[0] !== {32'h0000_1000, 32'hDEAD_BEEF})
            begin errors++; $display("FAIL wr_txn: count %0d first %h required 1 0000_1000_DEADBEEF",
                wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0); end
        checks++;
        if (wr_len_q.size() != 1 || wr_len_q[0] != 4)
            begin errors++; $display("FAIL wr_hold: got %0d cycles required 4",
                (wr_len_q.size() > 0) ? wr_len_q[0] : -1); end
        checks++;
        if (tx_q.size() != 1 || tx_packed() !== 32'h4B || rd_q.size() != 0 || err_pulses != 0)
            begin errors++; $display("FAIL wr_resp: tx n=%0d v=%h rd=%0d err=%0d required n=1 v=4b 0 0",
                tx_q.size(), tx_packed(), rd_q.size(), err_pulses); end
        wr_delay = 0;
    endtask

    task automatic test_read();
        bit ok, ok2;
        clear_logs(); rd_delay = 2; rd_data_val = 32'h0000_0041;
        send_frame(8'h52, 32'h0000_00FF, 32'h0, 0, ok);
        @(negedge clk);
        checks++;
        if (bus.o_rd_ready !== 1'b1)
            begin errors++; $display("FAIL rd_latency: rd_ready %b required 1", bus.o_rd_ready); end
        wait_idle(ok2);
        checks++;
        if (!(ok && ok2) || rd_q.size() != 1 || rd_q[0] !== 32'hFF || wr_q.size() != 0)
            begin errors++; $display("FAIL rd_txn: rd count %0d addr %h wr %0d required 1 000000ff 0",
                rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'h0, wr_q.size()); end
        checks++;
        if (tx_q.size() != 4 || tx_packed() !== 32'h0000_0041)
            begin errors++; $display("FAIL rd_resp: tx n=%0d v=%h required n=4 v=00000041",
                tx_q.size(), tx_packed()); end
        rd_delay = 0;
    endtask

    task automatic test_bad_cmd();
        bit ok, ok2;
        logic [31:0] a, d;
        clear_logs();
        send_frame(8'h13, 32'h0, 32'h0, 0, ok);
        wait_idle(ok2);
        checks++;
        if (!(ok && ok2) || tx_q.size() != 1 || tx_packed() !== 32'h3F)
            begin errors++; $display("FAIL bad_resp: tx n=%0d v=%h required n=1 v=3f",
                tx_q.size(), tx_packed()); end
        checks++;
        if (err_pulses != 1 || err_cycles != 1 || wr_q.size() != 0 || rd_q.size() != 0)
            begin errors++; $display("FAIL bad_err: pulses %0d cycles %0d wr %0d rd %0d required 1 1 0 0",
                err_pulses, err_cycles, wr_q.size(), rd_q.size()); end
        clear_logs();
        a = $urandom; d = $urandom; rd_data_val = d;
        send_frame(8'h52, a, 32'h0, 2, ok);
        wait_idle(ok2);
        checks++;
        if (!(ok && ok2) || rd_q.size() != 1 || rd_q[0] !== a || tx_q.size() != 4 || tx_packed() !== d)
            begin errors++; $display("FAIL after_bad_rd: rd %0d tx n=%0d v=%h required 1 n=4 v=%h",
                rd_q.size(), tx_q.size(), tx_packed(), d); end
    endtask

    task automatic test_timeout();
        bit ok, o, bad;
        clear_logs();
        send_byte(8'h57, 0, ok);
        send_byte(8'h00, 0, o); ok &= o;
        send_byte(8'h00, 0, o); ok &= o;
        bad = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || error !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (!ok || bad)
            begin errors++; $display("FAIL tmo_early: sent %b early_exit %b required 1 0", ok, bad); end
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL tmo_fire: error %b busy %b required 1 0", error, busy); end
        repeat (20) begin @(posedge clk); #1; end
        checks++;
        if (tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0 || err_pulses != 1 || err_cycles != 1)
            begin errors++; $display("FAIL tmo_after: tx %0d wr %0d rd %0d pulses %0d cycles %0d required 0 0 0 1 1",
                tx_q.size(), wr_q.size(), rd_q.size(), err_pulses, err_cycles); end
    endtask

    task automatic test_tx_stall();
        bit ok, ok2;
        logic [31:0] a, d;
        clear_logs(); tx_stall = 10;
        a = $urandom; d = $urandom; rd_data_val = d;
        tx_unstable = 0;
        send_frame(8'h52, a, 32'h0, 0, ok);
        wait_idle(ok2);
        checks++;
        if (!(ok && ok2) || tx_q.size() != 4 || tx_packed() !== d)
            begin errors++; $display("FAIL stall_resp: tx n=%0d v=%h required n=4 v=%h",
                tx_q.size(), tx_packed(), d); end
        checks++;
        if (tx_unstable != 0)
            begin errors++; $display("FAIL stall_stable: %0d data changes while stalled required 0", tx_unstable); end
        tx_stall = 0;
    endtask

    task automatic test_random(input int n);
        bit ok, ok2;
        int kind, exp_tx_n, exp_wr_n, exp_rd_n, exp_err;
        logic [7:0] cmd;
        logic [31:0] a, d, exp_tx_v;
        for (int f = 0; f < n; f++) begin
            clear_logs();
            kind = $urandom_range(0, 2);
            a = $urandom; d = $urandom; rd_data_val = $urandom;
            wr_delay = $urandom_range(0, 4); rd_delay = $urandom_range(0, 4);
            tx_stall = $urandom_range(0, 3);
            if (kind == 0) cmd = 8'h57;
            else if (kind == 1) cmd = 8'h52;
            else begin
                cmd = 8'($urandom);
                while (cmd == 8'h57 || cmd == 8'h52) cmd = 8'($urandom);
            end
            // frame -> expected observable effects
            exp_tx_n = (kind == 1) ? 4 : 1;
            exp_tx_v = (kind == 0) ? 32'h4B : (kind == 1) ? rd_data_val : 32'h3F;
            exp_wr_n = (kind == 0) ? 1 : 0;
            exp_rd_n = (kind == 1) ? 1 : 0;
            exp_err  = (kind == 2) ? 1 : 0;
            send_frame(cmd, a, d, 3, ok);
            wait_idle(ok2);
            checks++;
            if (!(ok && ok2) || tx_q.size() != exp_tx_n || tx_packed() !== exp_tx_v)
                begin errors++; $display("FAIL rnd_tx[%0d] cmd %h: n=%0d v=%h required n=%0d v=%h",
                    f, cmd, tx_q.size(), tx_packed(), exp_tx_n, exp_tx_v); end
            checks++;
            if (wr_q.size() != exp_wr_n || rd_q.size() != exp_rd_n || err_pulses != exp_err ||
                (exp_wr_n == 1 && (wr_q[0] !== {a, d} || wr_len_q[0] != wr_delay + 1)) ||
                (exp_rd_n == 1 && rd_q[0] !== a))
                begin errors++; $display("FAIL rnd_bus[%0d] cmd %h: wr %0d rd %0d err %0d required %0d %0d %0d addr %h",
                    f, cmd, wr_q.size(), rd_q.size(), err_pulses, exp_wr_n, exp_rd_n, exp_err, a); end
        end
        wr_delay = 0; rd_delay = 0; tx_stall = 0;
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        clear_logs(); wr_delay = 100;
        send_frame(8'h57, $urandom, $urandom, 0, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || bus.o_wr_valid !== 1'b1)
            begin errors++; $display("FAIL rstw_pre: wr_valid %b required 1", bus.o_wr_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o_wr_valid !== 1'b0 || busy !== 1'b0 || bus.o_rx_ready !== 1'b0)
            begin errors++; $display("FAIL rstw_async: wr_valid %b busy %b rx_ready %b required 0 0 0",
                bus.o_wr_valid, busy, bus.o_rx_ready); end
        @(posedge clk); #1;
        wr_delay = 0;
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks++;
        if (tx_q.size() != 0 || wr_q.size() != 0 || busy !== 1'b0)
            begin errors++; $display("FAIL rstw_after: tx %0d wr %0d busy %b required 0 0 0",
                tx_q.size(), wr_q.size(), busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_cmd();
        test_timeout();
        test_tx_stall();
        test_random(20);
        test_reset_mid_write();
        checks++;
        if (overlap != 0 || wr_unstable != 0)
            begin errors++; $display("FAIL bus_excl: overlap %0d unstable %0d required 0 0",
                overlap, wr_unstable); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, inter-byte receive timeout in clock cycles.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 i_rx_data  in  8  received UART byte.
REQ-005 i_rx_valid  in  1  i_rx_data holds a byte.
REQ-006 o_rx_ready  out  1  block accepts the byte; transfer occurs when i_rx_valid && o_rx_ready.
REQ-007 o_tx_data  out  8  response byte toward UART TX FIFO.
REQ-008 o_tx_valid  out  1  o_tx_data valid.
REQ-009 i_tx_ready  in  1  TX FIFO accepts the byte; transfer occurs when o_tx_valid && i_tx_ready.
REQ-010 o_addr  out  32  CPU-bus address.
REQ-011 o_data  out  32  CPU-bus write data.
REQ-012 o_wr_valid  out  1  write request; held until i_wr_ready.
REQ-013 i_wr_ready  in  1  write accepted.
REQ-014 i_data  in  32  CPU-bus read data.
REQ-015 i_rd_valid  in  1  read data valid.
REQ-016 o_rd_ready  out  1  read request; held until i_rd_valid.
REQ-017 o_busy  out  1  high in every state except IDLE.
REQ-018 o_error  out  1  one-cycle pulse on bad command byte or receive timeout.

Function
REQ-019 The block SHALL be a bus initiator driven by UART frames: cmd byte, 4 address bytes MSB first, then for writes 4 data bytes MSB first.
REQ-020 Cmd 0x57 ('W') SHALL issue one 32-bit write; cmd 0x52 ('R') SHALL issue one 32-bit read; any other cmd byte SHALL emit 0x3F ('?'), pulse o_error, return to IDLE.
REQ-021 States SHALL be IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RESP; a 2-bit byte counter SHALL index address/data bytes and response bytes.
REQ-022 o_rx_ready SHALL be high only in IDLE, ADDR, WDATA; each accepted byte SHALL shift into the addr/data register left by 8.
REQ-023 After the 4th address byte: 'R' -> BUS_RD; 'W' -> WDATA. After the 4th data byte -> BUS_WR.
REQ-024 BUS_WR: o_wr_valid=1 with stable o_addr/o_data; on the cycle i_wr_ready=1, deassert next cycle, load response 0x4B ('K'), go to RESP.
REQ-025 BUS_RD: o_rd_ready=1 with stable o_addr; on the cycle i_rd_valid=1, capture i_data, go to RESP with 4 response bytes MSB first.
REQ-026 o_wr_valid and o_rd_ready SHALL never be high simultaneously and SHALL not be high outside BUS_WR/BUS_RD.
REQ-027 RESP: o_tx_valid=1, o_tx_data stable until i_tx_ready; after the last byte transfers -> IDLE in the next cycle.
REQ-028 Bus wait and TX backpressure SHALL be unbounded (no timeout).
REQ-029 In ADDR/WDATA a cycle counter SHALL reset on each accepted byte; reaching TIMEOUT_CYCLES without a byte SHALL pulse o_error, discard the partial frame, return to IDLE, emit nothing.
REQ-030 RX bytes arriving while not ready SHALL stay pending upstream (no drop inside this block).
REQ-031 Bytes-in to bus-request latency SHALL be one cycle after the final frame byte is accepted.

Reset
REQ-032 On i_rst=0: state IDLE, counters 0, o_rx_ready=0 during reset, o_tx_valid=0, o_wr_valid=0, o_rd_ready=0, o_busy=0, o_error=0, o_addr=0, o_data=0, o_tx_data=0.
REQ-033 Reset mid-transaction SHALL abandon it immediately; no bus or TX handshake completes after reset asserts.
REQ-034 First RX byte SHALL be acceptable in the first cycle after reset release.

Structure
REQ-035 Package leg_dbg_pkg SHALL hold command/response byte constants (0x57, 0x52, 0x4B, 0x3F) and the state enum.
REQ-036 Single module; no sub-module required; instantiated in the top level alongside uartwriter, arbitrated against the core at the memmap input.

Verification
REQ-037 Frame 57 00 00 10 00 DE AD BE EF, i_wr_ready after 3 cycles -> one write addr 0x00001000 data 0xDEADBEEF, o_wr_valid held 4 cycles, TX 0x4B.
REQ-038 Frame 52 00 00 00 FF, i_rd_valid with i_data=0x00000041 after 2 cycles -> TX 00 00 00 41 in order.
REQ-039 Cmd 0x13 -> TX 0x3F, o_error pulse 1 cycle, no bus request, next 'R' frame works.
REQ-040 TIMEOUT_CYCLES=16, send 57 00 00 then silence 16 cycles -> o_error pulse, IDLE, no TX, no bus request.
REQ-041 Read response with i_tx_ready low 10 cycles per byte -> o_tx_data stable while stalled, 4 bytes delivered exactly once.
REQ-042 Assert i_rst during BUS_WR -> o_wr_valid=0 asynchronously, o_busy=0, no 'K' emitted after release.
